// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//
// Converts the spike line of a LIF neuron into a firing rate: the number of
// rising edges of spike seen in each back-to-back window of WINDOW cycles.
// Optionally it also measures the interval between consecutive spikes (ISI).
//
// Configuration macro:
//   SPIKE_DECODER_ISI_EN  - when defined, the ISI counter and isi/isi_valid
//                           registers are built; otherwise isi and isi_valid
//                           are tied to zero.
//
// Parameters:
//   WINDOW      measurement window length in clock cycles (2..65535)
//   OUT_W       width of the rate and isi outputs
//
// Ports:
//   clk         single clock, rising edge
//   rst_n       synchronous active-low reset
//   en          decoding enable; low returns the FSM to IDLE
//   spike       spike level from the neuron; only rising edges are counted
//   rate        saturated spike count of the last completed window
//   rate_valid  one-cycle pulse when rate is updated
//   isi         last inter-spike interval in cycles (saturated)
//   isi_valid   one-cycle pulse when isi is updated
//   busy        high while the FSM is in COUNT
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
    parameter int unsigned WINDOW = 256,
    parameter int unsigned OUT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike,
    output logic [OUT_W-1:0] rate,
    output logic             rate_valid,
    output logic [OUT_W-1:0] isi,
    output logic             isi_valid,
    output logic             busy
);

    localparam int unsigned      WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
    localparam logic [OUT_W-1:0] CNT_MAX  = '1;
    localparam logic [OUT_W-1:0] CNT_ONE  = OUT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             spike_q;
    logic [WIN_W-1:0] win_q, win_d;
    logic [OUT_W-1:0] spk_q, spk_d;
    logic [OUT_W-1:0] rate_q, rate_d;
    logic             rate_valid_q, rate_valid_d;

    logic             spike_evt;
    logic [OUT_W-1:0] spk_inc;

    // A level held high for several cycles is a single event.
    assign spike_evt = spike & ~spike_q;

    // Saturating count including the current cycle's event; used both for the
    // running count and for the value captured on the last window cycle.
    assign spk_inc = (spike_evt && (spk_q != CNT_MAX)) ? spk_q + CNT_ONE : spk_q;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        spk_d        = spk_q;
        rate_d       = rate_q;
        rate_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = COUNT;
                    win_d   = '0;
                    spk_d   = '0;
                end
            end
            COUNT: begin
                if (!en) begin
                    // Partial window is simply dropped; rate keeps its value.
                    state_d = IDLE;
                end else if (win_q == WIN_LAST) begin
                    rate_d       = spk_inc;
                    rate_valid_d = 1'b1;
                    win_d        = '0;
                    spk_d        = '0;
                end else begin
                    win_d = win_q + WIN_ONE;
                    spk_d = spk_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block
    // and rst_n is deliberately absent from the sensitivity list.
    // NOTE: state registers use non-blocking assignments so every register
    // samples its _d value from before this edge, independent of block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            spike_q      <= 1'b0;
            win_q        <= '0;
            spk_q        <= '0;
            rate_q       <= '0;
            rate_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            spike_q      <= spike;
            win_q        <= win_d;
            spk_q        <= spk_d;
            rate_q       <= rate_d;
            rate_valid_q <= rate_valid_d;
        end
    end

`ifdef SPIKE_DECODER_ISI_EN
    logic [OUT_W-1:0] isi_cnt_q, isi_cnt_d;
    logic             has_prev_q, has_prev_d;
    logic [OUT_W-1:0] isi_q, isi_d;
    logic             isi_valid_q, isi_valid_d;

    // The ISI counter runs across window boundaries; it is only cleared when
    // a new COUNT session starts. It restarts at 1 on an event so that its
    // value at the next event equals the distance between the two events.
    always_comb begin
        isi_cnt_d   = isi_cnt_q;
        has_prev_d  = has_prev_q;
        isi_d       = isi_q;
        isi_valid_d = 1'b0;

        if (state_q == IDLE) begin
            if (en) begin
                isi_cnt_d  = '0;
                has_prev_d = 1'b0;
            end
        end else if (en) begin
            if (spike_evt) begin
                if (has_prev_q) begin
                    isi_d       = isi_cnt_q;
                    isi_valid_d = 1'b1;
                end
                has_prev_d = 1'b1;
                isi_cnt_d  = CNT_ONE;
            end else if (isi_cnt_q != CNT_MAX) begin
                isi_cnt_d = isi_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            isi_cnt_q   <= '0;
            has_prev_q  <= 1'b0;
            isi_q       <= '0;
            isi_valid_q <= 1'b0;
        end else begin
            isi_cnt_q   <= isi_cnt_d;
            has_prev_q  <= has_prev_d;
            isi_q       <= isi_d;
            isi_valid_q <= isi_valid_d;
        end
    end

    assign isi       = isi_q;
    assign isi_valid = isi_valid_q;
`else
    assign isi       = '0;
    assign isi_valid = 1'b0;
`endif

    assign rate       = rate_q;
    assign rate_valid = rate_valid_q;
    assign busy       = (state_q == COUNT);

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_decoder
//
// Self-checking bench for spike_rate_decoder. A main instance (WINDOW=256,
// OUT_W=8) is driven from spike patterns; a reference model walks each
// pattern up front and queues the expected rate/isi values together with the
// cycle in which their valid pulse must appear. A negedge monitor pops and
// compares every pulse. A second instance with OUT_W=6 covers saturation.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

    localparam int WIN   = 256;
    localparam int MAXV  = 255;
    localparam int MAXV6 = 63;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, en, spike, en6, spike6;
    logic [7:0] rate, isi;
    logic       rate_valid, isi_valid, busy;
    logic [5:0] rate6, isi6;
    logic       rate_valid6, isi_valid6, busy6;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   last_rate   = 0;
    int   last_isi    = 0;
    exp_t exp_rate[$];
    exp_t exp_isi[$];
    exp_t e_r, e_i;
    bit   pat[0:1023];

    spike_rate_decoder #(.WINDOW(WIN), .OUT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .spike      (spike),
        .rate       (rate),
        .rate_valid (rate_valid),
        .isi        (isi),
        .isi_valid  (isi_valid),
        .busy       (busy)
    );

    spike_rate_decoder #(.WINDOW(WIN), .OUT_W(6)) dut6 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en6),
        .spike      (spike6),
        .rate       (rate6),
        .rate_valid (rate_valid6),
        .isi        (isi6),
        .isi_valid  (isi_valid6),
        .busy       (busy6)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every valid pulse must match the head of its queue,
    // both in value and in the cycle it appears.
    always @(negedge clk) begin
        if (rate_valid === 1'b1) begin
            vectors++;
            if (exp_rate.size() == 0) begin
                miscompares++;
                $display("FAIL rate_pulse: unexpected rate_valid at cycle %0d (rate=%0d), none required", cyc, rate);
            end else begin
                e_r = exp_rate.pop_front();
                if (rate !== 8'(e_r.val) || cyc != e_r.cyc) begin
                    miscompares++;
                    $display("FAIL rate_pulse: got rate=%0d at cycle %0d, required rate=%0d at cycle %0d",
                             rate, cyc, e_r.val, e_r.cyc);
                end
            end
        end
        if (isi_valid === 1'b1) begin
            vectors++;
            if (exp_isi.size() == 0) begin
                miscompares++;
                $display("FAIL isi_pulse: unexpected isi_valid at cycle %0d (isi=%0d), none required", cyc, isi);
            end else begin
                e_i = exp_isi.pop_front();
                if (isi !== 8'(e_i.val) || cyc != e_i.cyc) begin
                    miscompares++;
                    $display("FAIL isi_pulse: got isi=%0d at cycle %0d, required isi=%0d at cycle %0d",
                             isi, cyc, e_i.val, e_i.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pat();
        for (int i = 0; i < 1024; i++) pat[i] = 1'b0;
    endtask

    // Runs one COUNT session with spike = pat[i] in window-cycle i (session
    // index). With abort_idx >= 0 the session is cut at that index by dropping
    // en (use_rst=0) or by asserting rst_n (use_rst=1).
    task automatic run_pattern(input string name, input int n_idx, input int abort_idx,
                               input bit use_rst, input int soak);
        int c0, cnt, last_ev, stop, iv;
        bit prev, has_prev;
        stop = (abort_idx >= 0) ? abort_idx : n_idx;

        tick();
        en    = 1'b1;
        spike = 1'b0;
        c0    = cyc;

        // Reference model: rising edges, saturating count, windows of WIN.
        prev = 1'b0; cnt = 0; has_prev = 1'b0; last_ev = 0;
        for (int i = 0; i < stop; i++) begin
            if (pat[i] && !prev) begin
                if (cnt < MAXV) cnt++;
`ifdef SPIKE_DECODER_ISI_EN
                if (has_prev) begin
                    iv = (i - last_ev > MAXV) ? MAXV : i - last_ev;
                    exp_isi.push_back('{iv, c0 + i + 2});
                    last_isi = iv;
                end
`endif
                has_prev = 1'b1;
                last_ev  = i;
            end
            prev = pat[i];
            if (i % WIN == WIN - 1) begin
                exp_rate.push_back('{cnt, c0 + i + 2});
                last_rate = cnt;
                cnt = 0;
            end
        end

        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_before_count: got %b, required 0", name, busy);
        end

        for (int i = 0; i < stop; i++) begin
            tick();
            spike = pat[i];
            if (i == 0) begin
                @(negedge clk);
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL %s busy_in_count: got %b, required 1", name, busy);
                end
            end
        end

        tick();
        spike = 1'b0;
        if (abort_idx >= 0 && use_rst) rst_n = 1'b0;
        else en = 1'b0;

        tick();
        rst_n = 1'b1;
        en    = 1'b0;
        if (abort_idx >= 0 && use_rst) begin
            last_rate = 0;
            last_isi  = 0;
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s busy_after_stop: got %b, required 0", name, busy);
        end
        vectors++;
        if (rate !== 8'(last_rate)) begin
            miscompares++;
            $display("FAIL %s rate_retained: got %0d, required %0d", name, rate, last_rate);
        end
        vectors++;
        if (isi !== 8'(last_isi)) begin
            miscompares++;
            $display("FAIL %s isi_retained: got %0d, required %0d", name, isi, last_isi);
        end

        // Spike activity while idle must not produce any pulse.
        for (int j = 0; j < soak; j++) begin
            tick();
            spike = (j % 3 == 0);
        end
        tick();
        spike = 1'b0;
        vectors++;
        if (exp_rate.size() != 0 || exp_isi.size() != 0) begin
            miscompares++;
            $display("FAIL %s pending_pulses: got %0d rate and %0d isi still outstanding, required 0",
                     name, exp_rate.size(), exp_isi.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; spike = 1'b1; en6 = 1'b0; spike6 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (rate !== 8'd0 || rate_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rate: got rate=%0d rate_valid=%b, required 0/0", rate, rate_valid);
        end
        vectors++;
        if (isi !== 8'd0 || isi_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_isi: got isi=%0d isi_valid=%b, required 0/0", isi, isi_valid);
        end
        vectors++;
        if (busy !== 1'b0 || busy6 !== 1'b0 || rate6 !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_busy: got busy=%b busy6=%b rate6=%0d, required 0/0/0", busy, busy6, rate6);
        end
        tick();
        rst_n = 1'b1; en = 1'b0; spike = 1'b0;
    endtask

    task automatic test_periodic();
        clear_pat();
        for (int i = 0; i < WIN; i += 8) pat[i] = 1'b1;
        run_pattern("periodic", WIN, -1, 1'b0, 8);
    endtask

    task automatic test_held();
        clear_pat();
        for (int i = 0; i < WIN; i++) pat[i] = 1'b1;
        run_pattern("held", WIN, -1, 1'b0, 8);
    endtask

    // Events on the last cycle of a window and on the first cycle of the next.
    task automatic test_boundary();
        clear_pat();
        pat[3]   = 1'b1;
        pat[255] = 1'b1;
        pat[257] = 1'b1;
        pat[510] = 1'b1;
        pat[512] = 1'b1;
        run_pattern("boundary", 3 * WIN, -1, 1'b0, 8);
    endtask

    task automatic test_isi();
        clear_pat();
        pat[10]  = 1'b1;
        pat[30]  = 1'b1;
        pat[330] = 1'b1;
        run_pattern("isi", 2 * WIN, -1, 1'b0, 8);
    endtask

    task automatic test_abort_en();
        clear_pat();
        pat[5]  = 1'b1;
        pat[50] = 1'b1;
        run_pattern("abort_en", WIN, 100, 1'b0, 300);
    endtask

    task automatic test_abort_rst();
        clear_pat();
        pat[7]  = 1'b1;
        pat[60] = 1'b1;
        run_pattern("abort_rst", WIN, 100, 1'b1, 300);
    endtask

    task automatic test_saturate();
        int  cnt;
        bit  prev;
        tick();
        en6 = 1'b1; spike6 = 1'b0;
        cnt = 0; prev = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            tick();
            spike6 = (i % 2 == 0);
            if (spike6 && !prev && cnt < MAXV6) cnt++;
            prev = spike6;
        end
        @(negedge clk);
        vectors++;
        if (rate_valid6 !== 1'b0) begin
            miscompares++;
            $display("FAIL saturate_early: got rate_valid6=%b on last window cycle, required 0", rate_valid6);
        end
        tick();
        spike6 = 1'b0; en6 = 1'b0;
        @(negedge clk);
        vectors++;
        if (rate_valid6 !== 1'b1 || rate6 !== 6'(cnt)) begin
            miscompares++;
            $display("FAIL saturate_rate: got rate_valid6=%b rate6=%0d, required 1/%0d", rate_valid6, rate6, cnt);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rate_valid6 !== 1'b0 || busy6 !== 1'b0) begin
            miscompares++;
            $display("FAIL saturate_after: got rate_valid6=%b busy6=%b, required 0/0", rate_valid6, busy6);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; spike = 1'b0; en6 = 1'b0; spike6 = 1'b0;
        test_reset();
        test_periodic();
        test_held();
        test_boundary();
        test_isi();
        test_saturate();
        test_abort_en();
        test_abort_rst();
        repeat (4) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
